fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the multi-cycle RV32I core.
- Generates word-aligned fetch addresses and issues reads to instruction memory, one outstanding at most.
- Buffers returned words with their PCs in a small FIFO and hands them to the core over a valid/ready interface.
- Takes redirects (taken branch, JAL, JALR) from the core, flushes buffered and in-flight fetches, and restarts at the new PC.

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory read, small PC-tagged FIFO, redirect flush.
// Define FETCH_BYPASS_EN to forward a response straight to the core when the FIFO is empty.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH      = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0] RESET_PC = RESET_ADDR & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        data_q [DEPTH];
  logic [31:0]        pc_q   [DEPTH];

  logic accept, rsp_wait, fifo_valid, bypass_take, bypass_consume, push, pop;

  assign accept     = mem_req && mem_ready;
  assign rsp_wait   = (state_q == WAIT) && mem_rvalid;
  assign fifo_valid = (count_q != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass_take = rsp_wait && !redirect && !fifo_valid && !reset;
`else
  assign bypass_take = 1'b0;
`endif
  assign bypass_consume = bypass_take && instr_ready;

  // Redirect overrides both push and pop in the same cycle.
  assign push = rsp_wait && !redirect && !bypass_consume;
  assign pop  = fifo_valid && instr_ready && !redirect;

  always_comb begin
    count_d    = redirect ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));
    fetch_pc_d = fetch_pc_q;
    if (redirect)      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
    else if (rsp_wait) fetch_pc_d = fetch_pc_q + 32'd4;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (redirect || (count_q < DEPTH_C)) state_d = REQ;
      REQ: begin
        if (redirect)    state_d = accept ? DROP : REQ;
        else if (accept) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid)    state_d = (redirect || (count_d < DEPTH_C)) ? REQ : IDLE;
        else if (redirect) state_d = DROP;
      end
      DROP: if (mem_rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // FSM / datapath outputs; reset forces the reset-time values even before the first edge
  always_comb begin
    mem_req     = 1'b0;
    mem_addr    = fetch_pc_q;
    instr_valid = 1'b0;
    instr       = '0;
    instr_pc    = '0;
    if (reset) begin
      mem_addr = RESET_PC;
    end else begin
      mem_req = (state_q == REQ);
      if (fifo_valid) begin
        instr_valid = 1'b1;
        instr       = data_q[rd_ptr_q];
        instr_pc    = pc_q[rd_ptr_q];
      end else if (bypass_take) begin
        instr_valid = 1'b1;
        instr       = mem_rdata;
        instr_pc    = fetch_pc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= mem_rdata;
      pc_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: directed scenarios followed by randomized traffic,
// checked against an expected sequential-PC instruction stream rebuilt on every restart.
module tb_fetch_unit;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam int unsigned DEPTH      = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  fetch_unit #(.RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  bit   rnd_mode  = 1'b0;
  int   fixed_dly = 0;

  // Instruction memory contents: distinct word per address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Fetch restarts at pc: the core must then see pc, pc+4, pc+8, ...
  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back(pc + 32'(4 * i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input string name, output logic [31:0] a);
    bit found = 1'b0;
    a = 32'hFFFF_FFFF;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_ready) begin
        a = mem_addr;
        found = 1'b1;
      end
    end
    if (!found) begin
      n_checks++;
      $display("FAIL %s: no request accepted within 100 cycles", name);
    end
  endtask

  // Memory model: one outstanding read, response delay 0..3 extra cycles.
  initial begin
    logic        acc;
    logic [31:0] acc_addr;
    logic        pend;
    logic [31:0] pend_addr;
    int          dly;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    pend = 1'b0; pend_addr = '0; dly = 0;
    forever begin
      @(negedge clk);
      acc      = mem_req && mem_ready;
      acc_addr = mem_addr;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (acc) begin
        pend      = 1'b1;
        pend_addr = acc_addr;
        dly       = rnd_mode ? int'($urandom_range(0, 3)) : fixed_dly;
      end
      if (pend) begin
        if (dly == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = word_of(pend_addr);
          pend       = 1'b0;
        end else begin
          dly--;
        end
      end
      mem_ready = !pend && (rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: every handshake pops the scoreboard; idle outputs must be zero.
  initial begin
    logic [31:0] p;
    forever begin
      @(negedge clk);
      if (reset) check("req_in_reset", mem_req, 0);
      if (mem_req) check("mem_addr_align", {30'b0, mem_addr[1:0]}, 0);
      if (!instr_valid) begin
        check("idle_instr", instr, 0);
        check("idle_instr_pc", instr_pc, 0);
      end
      if (!reset && !redirect && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_empty: got instr_pc %h with no instruction expected", instr_pc);
        end else begin
          p = exp_q.pop_front();
          check("instr_pc", instr_pc, p);
          check("instr", instr, word_of(p));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic        v0, v1;
    logic [31:0] addrs[$];
    int          idle_req;

    reset = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    restart(RESET_ADDR);
    repeat (3) tick();

    // Reset release and sequential fetch with 1-cycle memory
    reset = 1'b0;
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, RESET_ADDR);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr_pc", instr_pc, 0);
    wait_acc("first_req", a);
    check("first_addr", a, RESET_ADDR);
    @(negedge clk);
    check("first_rvalid", mem_rvalid, 1);
    v0 = instr_valid;
    @(negedge clk);
    v1 = instr_valid;
`ifdef FETCH_BYPASS_EN
    check("lat_bypass_same_cycle", v0, 1);
`else
    check("lat_no_comb_path", v0, 0);
    check("lat_next_cycle", v1, 1);
`endif
    repeat (12) tick();

    // Back-pressure: FIFO fills with two entries, then fetch stops
    reset = 1'b1; instr_ready = 1'b0; restart(RESET_ADDR);
    tick();
    reset = 1'b0;
    idle_req = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req && mem_ready) addrs.push_back(mem_addr);
      if (i >= 12 && mem_req) idle_req++;
    end
    check("full_req_count", addrs.size(), 2);
    check("full_req0", (addrs.size() > 0) ? addrs[0] : 32'hFFFF_FFFF, 32'h0);
    check("full_req1", (addrs.size() > 1) ? addrs[1] : 32'hFFFF_FFFF, 32'h4);
    check("full_no_req", idle_req, 0);
    tick();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    fixed_dly = 2;
    wait_acc("after_pop_req", a);
    check("after_pop_addr", a, 32'h8);

    // Redirect while waiting on 0x8
    tick();
    redirect = 1'b1; redirect_pc = 32'h100; restart(32'h100);
    tick();
    redirect = 1'b0; fixed_dly = 0;
    @(negedge clk);
    check("redir_flush", instr_valid, 0);
    tick();
    instr_ready = 1'b1;
    wait_acc("redir_req", a);
    check("redir_addr", a, 32'h100);
    repeat (8) tick();

    // Unaligned redirect while idle with a full FIFO
    instr_ready = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    check("full_idle_req", mem_req, 0);
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0203; restart(32'h200);
    tick();
    redirect = 1'b0; instr_ready = 1'b1;
    wait_acc("unaligned_req", a);
    check("unaligned_addr", a, 32'h200);
    repeat (8) tick();

    // Redirect coinciding with a pop and a response
    reset = 1'b1; instr_ready = 1'b0; restart(RESET_ADDR);
    tick();
    reset = 1'b0;
    wait_acc("coinc_req0", a);
    wait_acc("coinc_req1", a);
    check("coinc_req1_addr", a, 32'h4);
    tick();
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h300; restart(32'h300);
    @(negedge clk);
    check("coinc_rvalid", mem_rvalid, 1);
    check("coinc_valid", instr_valid, 1);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("coinc_flush", instr_valid, 0);
    check("coinc_req", mem_req, 1);
    check("coinc_addr", mem_addr, 32'h300);
    repeat (8) tick();

    // Reset while waiting; the late response must be ignored
    fixed_dly = 2;
    wait_acc("rstwait_req", a);
    tick();
    reset = 1'b1; restart(RESET_ADDR);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rstwait_req_low", mem_req, 0);
    check("rstwait_valid", instr_valid, 0);
    check("rstwait_addr", mem_addr, RESET_ADDR);
    @(negedge clk);
    check("rstwait_stale_rvalid", mem_rvalid, 1);
    check("rstwait_restart_req", mem_req, 1);
    check("rstwait_restart_addr", mem_addr, RESET_ADDR);
    fixed_dly = 0;
    repeat (10) tick();

    // Randomized traffic: back-pressure, memory stalls, redirects (incl. wrap), resets
    rnd_mode = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      instr_ready = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 39) == 0);
      if (redirect) begin
        case ($urandom_range(0, 2))
          0:       redirect_pc = $urandom;
          1:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
          default: redirect_pc = 32'($urandom_range(0, 255));
        endcase
        restart(redirect_pc & 32'hFFFF_FFFC);
      end
      reset = ($urandom_range(0, 499) == 0);
      if (reset) restart(RESET_ADDR);
    end
    tick();
    rnd_mode = 1'b0; reset = 1'b0; redirect = 1'b0; instr_ready = 1'b1;
    repeat (30) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
